// File: rtl/qsn_sel_gen_len15_if.sv
// Control channel of the length-15 QSN selector generator: shift-factor request in, shifter/merge controls out.
// master = upstream/downstream environment side, slave = the generator block.
interface qsn_sel_gen_len15_if;
    logic [3:0]  shift_factor;
    logic        dir;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  left_sft;
    logic [3:0]  right_sft;
    logic [13:0] merge_sel;
    logic        shift_err;
    logic [7:0]  err_cnt;

    modport master (
        output shift_factor, dir, in_valid, out_ready,
        input  in_ready, out_valid, left_sft, right_sft, merge_sel, shift_err, err_cnt
    );

    modport slave (
        input  shift_factor, dir, in_valid, out_ready,
        output in_ready, out_valid, left_sft, right_sft, merge_sel, shift_err, err_cnt
    );
endinterface

// File: rtl/qsn_sel_gen_len15.sv
// Purpose: decode a circulant shift factor into left/right shifter amounts and merge select for a Z=15 QSN.
// Latency: PIPE_STAGES-1 cycles after the accepting edge (registered output from the last slot).
// Backpressure: a held last-stage output freezes every slot (bubbles included); in_ready drops combinationally.
module qsn_sel_gen_len15 #(
    parameter int PIPE_STAGES = 2,
    parameter int Z           = 15
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    qsn_sel_gen_len15_if.slave   bus
);
    typedef struct packed {
        logic [3:0]  left;
        logic [3:0]  right;
        logic [13:0] sel;
        logic        err;
    } ctl_t;

    localparam ctl_t CTL_RST = '{left: 4'd0, right: 4'd0, sel: 14'h3FFF, err: 1'b0};

    logic [PIPE_STAGES-1:0] vld;
    ctl_t                   dat [PIPE_STAGES];
    ctl_t                   dec;
    logic [3:0]             s_in;
    logic [3:0]             s_eff;
    logic                   stall;
    logic                   accept;
    logic [7:0]             err_cnt_q;

    assign stall  = vld[PIPE_STAGES-1] && !bus.out_ready;
    assign accept = bus.in_valid && !stall;

    // An illegal factor of 15 is treated as a zero shift and flagged on the sideband.
    always_comb begin
        dec   = CTL_RST;
        s_in  = (bus.shift_factor == 4'd15) ? 4'd0 : bus.shift_factor;
        s_eff = (!bus.dir || s_in == 4'd0) ? s_in : 4'(Z) - s_in;
        dec.left  = s_eff;
        dec.right = (s_eff == 4'd0) ? 4'd0 : 4'(Z) - s_eff;
        dec.err   = (bus.shift_factor == 4'd15);
        for (int i = 0; i < 14; i++) begin
            dec.sel[i] = (i < (Z - int'(s_eff)));
        end
    end

    // Slot payloads only load when a valid entry moves in, so the last slot keeps its value across bubbles.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                dat[i] <= CTL_RST;
            end
        end else if (!stall) begin
            vld[0] <= accept;
            if (accept) begin
                dat[0] <= dec;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (accept && bus.shift_factor == 4'd15 && err_cnt_q != 8'd255) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = vld[PIPE_STAGES-1];
    assign bus.left_sft  = dat[PIPE_STAGES-1].left;
    assign bus.right_sft = dat[PIPE_STAGES-1].right;
    assign bus.merge_sel = dat[PIPE_STAGES-1].sel;
    assign bus.shift_err = dat[PIPE_STAGES-1].err;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_qsn_sel_gen_len15.sv
// Bench for qsn_sel_gen_len15: queue-based reference with per-entry pipeline age, plus literal spot checks.
module tb_qsn_sel_gen_len15;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qsn_sel_gen_len15_if bus ();

    qsn_sel_gen_len15 #(.PIPE_STAGES(P), .Z(15)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        int l;
        int r;
        int m;
        int e;
        int age;
    } ent_t;

    ent_t q[$];
    int   mcnt   = 0;
    int   total  = 0;
    int   bad    = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Rotation expressed as a modular shift: inverse of s is -s mod 15.
    function automatic ent_t mdl(input int sf, input bit d);
        ent_t e;
        int   s;
        s     = (sf == 15) ? 0 : sf;
        e.l   = d ? (15 - s) % 15 : s;
        e.r   = (15 - e.l) % 15;
        e.m   = ((1 << (15 - e.l)) - 1) & 'h3FFF;
        e.e   = (sf == 15) ? 1 : 0;
        e.age = 0;
        return e;
    endfunction

    // Reference update at the clock edge, using pre-edge signal values.
    always @(posedge clk) begin
        bit ev;
        bit st;
        if (rst) begin
            q.delete();
            mcnt   = 0;
            chk_en = 1'b1;
        end else begin
            ev = (q.size() > 0) && (q[0].age == P - 1);
            st = ev && !bus.out_ready;
            if (ev && bus.out_ready) void'(q.pop_front());
            if (!st) begin
                foreach (q[i]) q[i].age++;
                if (bus.in_valid) begin
                    q.push_back(mdl(int'(bus.shift_factor), bus.dir));
                    if (bus.shift_factor == 4'd15 && mcnt < 255) mcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = (q.size() > 0) && (q[0].age == P - 1);
            chk("out_valid", int'(bus.out_valid), int'(ev));
            chk("in_ready", int'(bus.in_ready), int'(!(ev && !bus.out_ready)));
            chk("err_cnt", int'(bus.err_cnt), mcnt);
            if (ev) begin
                chk("left_sft", int'(bus.left_sft), q[0].l);
                chk("right_sft", int'(bus.right_sft), q[0].r);
                chk("merge_sel", int'(bus.merge_sel), q[0].m);
                chk("shift_err", int'(bus.shift_err), q[0].e);
            end
        end
    end

    // Drive one isolated input into an empty pipe and check the literal result at the expected cycle.
    task automatic single(input int s, input bit d, input int el, input int er, input int em, input int ee);
        bus.shift_factor = 4'(s);
        bus.dir          = d;
        bus.in_valid     = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (P - 1) @(posedge clk);
        @(negedge clk);
        chk("lit_valid", int'(bus.out_valid), 1);
        chk("lit_left", int'(bus.left_sft), el);
        chk("lit_right", int'(bus.right_sft), er);
        chk("lit_merge", int'(bus.merge_sel), em);
        chk("lit_err", int'(bus.shift_err), ee);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input bit d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.shift_factor = 4'(s);
        bus.dir          = d;
        bus.in_valid     = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("send_accept", int'(acc), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.shift_factor = 4'd5;
        bus.dir          = 1'b0;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b1;
        rst              = 1'b1;

        // Reset with a valid input pending: nothing is taken, outputs at reset values.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_merge", int'(bus.merge_sel), 'h3FFF);
            chk("rst_left", int'(bus.left_sft), 0);
            chk("rst_right", int'(bus.right_sft), 0);
            chk("rst_shift_err", int'(bus.shift_err), 0);
            chk("rst_err_cnt", int'(bus.err_cnt), 0);
            chk("rst_in_ready", int'(bus.in_ready), 1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (P) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Forward sweep back-to-back.
        bus.dir = 1'b0;
        for (int s = 0; s < 15; s++) begin
            bus.shift_factor = 4'(s);
            bus.in_valid     = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (P + 2) @(posedge clk);
        #1;

        single(3, 1'b0, 3, 12, 'h0FFF, 0);
        single(14, 1'b0, 14, 1, 'h0001, 0);
        single(0, 1'b0, 0, 0, 'h3FFF, 0);
        single(1, 1'b0, 1, 14, 'h3FFF, 0);
        single(3, 1'b1, 12, 3, 'h0007, 0);
        single(0, 1'b1, 0, 0, 'h3FFF, 0);

        // Backpressure: three-cycle stall right after the first output is consumed.
        fork
            begin
                for (int s = 1; s <= 4; s++) send(s, 1'b0);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first_out", int'(bus.out_valid), 1);
                @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("bp_drained", q.size(), 0);

        // Illegal factor stream with toggling direction; counter must saturate.
        for (int i = 0; i < 300; i++) begin
            bus.shift_factor = 4'd15;
            bus.dir          = i[0];
            bus.in_valid     = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (P + 2) @(posedge clk);
        @(negedge clk);
        chk("err_cnt_sat", int'(bus.err_cnt), 255);
        @(posedge clk);
        #1;
        single(15, 1'b1, 0, 0, 'h3FFF, 1);

        // Mid-stream reset with two entries in flight.
        bus.dir          = 1'b0;
        bus.shift_factor = 4'd5;
        bus.in_valid     = 1'b1;
        @(posedge clk);
        #1 bus.shift_factor = 4'd6;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_flush", int'(bus.out_valid), 0);
        chk("midrst_err_cnt", int'(bus.err_cnt), 0);
        @(negedge clk);
        chk("midrst_flush2", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        single(7, 1'b0, 7, 8, 'h00FF, 0);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
